// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: coin and change encodings,
// error codes, FSM states and the slot price rule.
package vend_pkg;

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  localparam logic [3:0] CoinOh500  = 4'b0001;
  localparam logic [3:0] CoinOh1000 = 4'b0010;
  localparam logic [3:0] CoinOh2000 = 4'b0100;
  localparam logic [3:0] CoinOh5000 = 4'b1000;

  localparam int unsigned CoinVal500  = 500;
  localparam int unsigned CoinVal1000 = 1000;
  localparam int unsigned CoinVal2000 = 2000;
  localparam int unsigned CoinVal5000 = 5000;

  localparam logic [2:0] Chg500  = 3'b001;
  localparam logic [2:0] Chg1000 = 3'b010;
  localparam logic [2:0] Chg2000 = 3'b100;

  localparam logic [2:0] ErrNone        = 3'd0;
  localparam logic [2:0] ErrInvalidCoin = 3'd1;
  localparam logic [2:0] ErrNoCredit    = 3'd2;
  localparam logic [2:0] ErrSoldOut     = 3'd3;
  localparam logic [2:0] ErrOverflow    = 3'd4;
  localparam logic [2:0] ErrBadState    = 3'd5;

  function automatic int unsigned price_of(input int unsigned idx, input int unsigned step);
    return (idx + 1) * step;
  endfunction

endpackage

// File: rtl/vend_controller_change.sv
// Greedy change selection: picks the largest returnable coin not exceeding the credit.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned TOTAL_W = 16
) (
  input  logic [TOTAL_W-1:0] credit_i,
  output logic [2:0]         coin_o,
  output logic [TOTAL_W-1:0] value_o
);

  always_comb begin
    coin_o  = 3'b000;
    value_o = '0;
    if (credit_i >= TOTAL_W'(CoinVal2000)) begin
      coin_o  = Chg2000;
      value_o = TOTAL_W'(CoinVal2000);
    end else if (credit_i >= TOTAL_W'(CoinVal1000)) begin
      coin_o  = Chg1000;
      value_o = TOTAL_W'(CoinVal1000);
    end else if (credit_i >= TOTAL_W'(CoinVal500)) begin
      coin_o  = Chg500;
      value_o = TOTAL_W'(CoinVal500);
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending controller: coin acceptance, product selection, per-slot stock, inactivity
// refund and greedy change return in one registered FSM.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS = 8,
  parameter int unsigned PRICE_STEP   = 500,
  parameter int unsigned TOTAL_W      = 16,
  parameter int unsigned MAX_CREDIT   = 20000,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned STOCK_INIT   = 4,
  parameter int unsigned TIMEOUT      = 255,
  localparam int unsigned ADDR_W      = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    coin_valid,
  input  logic [3:0]              coin_type,
  input  logic                    select_valid,
  input  logic [ADDR_W-1:0]       select_addr,
  input  logic                    cancel,
  output logic [TOTAL_W-1:0]      credit,
  output logic                    vend_valid,
  output logic [ADDR_W-1:0]       vend_addr,
  output logic                    change_valid,
  output logic [2:0]              change_coin,
  output logic                    coin_reject,
  output logic [2:0]              error,
  output logic [NUM_PRODUCTS-1:0] sold_out,
  output logic                    busy
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
  localparam int unsigned SUM_W   = TOTAL_W + 1;

  state_e               state_q, state_d;
  logic [TOTAL_W-1:0]   credit_q, credit_d;
  logic                 vend_valid_q, vend_valid_d;
  logic [ADDR_W-1:0]    vend_addr_q, vend_addr_d;
  logic                 change_valid_q, change_valid_d;
  logic [2:0]           change_coin_q, change_coin_d;
  logic                 coin_reject_q, coin_reject_d;
  logic [2:0]           error_q, error_d;
  logic [STOCK_W-1:0]   stock_q [NUM_PRODUCTS];
  logic [STOCK_W-1:0]   stock_d [NUM_PRODUCTS];
  logic [TIMER_W-1:0]   timer_q, timer_d;

  logic [TOTAL_W-1:0]   price_tbl [NUM_PRODUCTS];
  logic [SUM_W-1:0]     coin_val;
  logic [SUM_W-1:0]     coin_sum;
  logic                 coin_fits;
  logic [31:0]          sel_idx;
  logic                 in_stock;
  logic [TOTAL_W-1:0]   price_sel;
  logic                 afford;
  logic [2:0]           chg_coin;
  logic [TOTAL_W-1:0]   chg_val;
  logic                 taken;

  for (genvar i = 0; i < NUM_PRODUCTS; i++) begin : g_price
    assign price_tbl[i] = TOTAL_W'(price_of(i, PRICE_STEP));
  end

  always_comb begin
    case (coin_type)
      CoinOh500:  coin_val = SUM_W'(CoinVal500);
      CoinOh1000: coin_val = SUM_W'(CoinVal1000);
      CoinOh2000: coin_val = SUM_W'(CoinVal2000);
      CoinOh5000: coin_val = SUM_W'(CoinVal5000);
      default:    coin_val = '0;
    endcase
  end

  // One extra bit so the ceiling check itself can never wrap.
  assign coin_sum  = {1'b0, credit_q} + coin_val;
  assign coin_fits = coin_sum <= SUM_W'(MAX_CREDIT);

  // Out-of-range slots read as sold out.
  assign sel_idx   = 32'(select_addr);
  assign in_stock  = (sel_idx < NUM_PRODUCTS) && (stock_q[select_addr] != '0);
  assign price_sel = price_tbl[select_addr];
  assign afford    = credit_q >= price_sel;

  change_dispenser #(
    .TOTAL_W (TOTAL_W)
  ) u_change (
    .credit_i (credit_q),
    .coin_o   (chg_coin),
    .value_o  (chg_val)
  );

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    vend_valid_d   = 1'b0;
    vend_addr_d    = vend_addr_q;
    change_valid_d = 1'b0;
    change_coin_d  = 3'b000;
    coin_reject_d  = 1'b0;
    error_d        = error_q;
    stock_d        = stock_q;
    timer_d        = timer_q;
    taken          = 1'b0;

    case (state_q)
      StIdle, StCollect: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          if (state_q == StCollect) state_d = StChange;
        end else if (select_valid) begin
          coin_reject_d = coin_valid;
          if (!in_stock) begin
            error_d = ErrSoldOut;
          end else if (!afford) begin
            error_d = ErrNoCredit;
          end else begin
            credit_d             = credit_q - price_sel;
            stock_d[select_addr] = stock_q[select_addr] - STOCK_W'(1);
            state_d              = StVend;
            vend_valid_d         = 1'b1;
            vend_addr_d          = select_addr;
            error_d              = ErrNone;
            taken                = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_val == '0) begin
            coin_reject_d = 1'b1;
            error_d       = ErrInvalidCoin;
          end else if (!coin_fits) begin
            coin_reject_d = 1'b1;
            error_d       = ErrOverflow;
          end else begin
            credit_d = coin_sum[TOTAL_W-1:0];
            state_d  = StCollect;
            error_d  = ErrNone;
            taken    = 1'b1;
          end
        end

        // Timer only runs while sitting in COLLECT with nothing accepted.
        if (state_q == StCollect && state_d == StCollect && !taken) begin
          if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
            state_d = StChange;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end else begin
          timer_d = '0;
        end
      end

      StVend: begin
        coin_reject_d = coin_valid;
        state_d       = (credit_q != '0) ? StChange : StIdle;
      end

      StChange: begin
        coin_reject_d = coin_valid;
        if (chg_coin != 3'b000) begin
          change_valid_d = 1'b1;
          change_coin_d  = chg_coin;
          credit_d       = credit_q - chg_val;
        end else begin
          credit_d = '0;
        end
        if (credit_d == '0) state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        error_d = ErrBadState;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      vend_valid_q   <= 1'b0;
      vend_addr_q    <= '0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 3'b000;
      coin_reject_q  <= 1'b0;
      error_q        <= ErrNone;
      timer_q        <= '0;
      for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      vend_valid_q   <= vend_valid_d;
      vend_addr_q    <= vend_addr_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      error_q        <= error_d;
      timer_q        <= timer_d;
      stock_q        <= stock_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
      sold_out[i] = (stock_q[i] == '0);
    end
  end

  assign credit       = credit_q;
  assign vend_valid   = vend_valid_q;
  assign vend_addr    = vend_addr_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign coin_reject  = coin_reject_q;
  assign error        = error_q;
  assign busy         = (state_q == StVend) || (state_q == StChange);

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios then random traffic, all checked against a
// cycle-level behavioural model of the vending rules.
module tb_vend_controller;

  localparam int NP   = 8;
  localparam int TOUT = 255;
  localparam int MAXC = 20000;
  localparam int SINIT = 4;

  localparam int MIdle = 0, MCollect = 1, MVend = 2, MChange = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        coin_valid = 1'b0;
  logic [3:0]  coin_type = 4'b0;
  logic        select_valid = 1'b0;
  logic [2:0]  select_addr = 3'b0;
  logic        cancel = 1'b0;
  logic [15:0] credit;
  logic        vend_valid;
  logic [2:0]  vend_addr;
  logic        change_valid;
  logic [2:0]  change_coin;
  logic        coin_reject;
  logic [2:0]  error;
  logic [7:0]  sold_out;
  logic        busy;

  vend_controller #(
    .NUM_PRODUCTS (NP),
    .PRICE_STEP   (500),
    .TOTAL_W      (16),
    .MAX_CREDIT   (MAXC),
    .STOCK_W      (4),
    .STOCK_INIT   (SINIT),
    .TIMEOUT      (TOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .select_valid (select_valid),
    .select_addr  (select_addr),
    .cancel       (cancel),
    .credit       (credit),
    .vend_valid   (vend_valid),
    .vend_addr    (vend_addr),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .coin_reject  (coin_reject),
    .error        (error),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state and the outputs it expects after the coming edge.
  int m_mode, m_credit, m_err, m_idle;
  int m_stock [NP];
  int e_vend, e_vaddr, e_chg, e_ccoin, e_rej;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int coin_value(input logic [3:0] t);
    case (t)
      4'b0001: return 500;
      4'b0010: return 1000;
      4'b0100: return 2000;
      4'b1000: return 5000;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_credit = 0; m_err = 0; m_idle = 0;
    for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
    e_vend = 0; e_vaddr = 0; e_chg = 0; e_ccoin = 0; e_rej = 0;
  endtask

  task automatic model_step(input bit cv, input logic [3:0] ct, input bit sv, input int sa,
                            input bit cn);
    int prev, val, price, coins[3], codes[3];
    bit taken;
    coins = '{2000, 1000, 500};
    codes = '{4, 2, 1};
    prev = m_mode; taken = 0;
    e_vend = 0; e_chg = 0; e_ccoin = 0; e_rej = 0;
    if (m_mode == MIdle || m_mode == MCollect) begin
      if (cn) begin
        e_rej = cv;
        if (m_mode == MCollect) m_mode = MChange;
      end else if (sv) begin
        e_rej = cv;
        price = (sa + 1) * 500;
        if (sa >= NP || m_stock[sa] == 0) m_err = 3;
        else if (m_credit < price) m_err = 2;
        else begin
          m_credit -= price; m_stock[sa]--; m_mode = MVend; m_err = 0;
          e_vend = 1; e_vaddr = sa; taken = 1;
        end
      end else if (cv) begin
        val = coin_value(ct);
        if (val == 0) begin e_rej = 1; m_err = 1; end
        else if (m_credit + val > MAXC) begin e_rej = 1; m_err = 4; end
        else begin m_credit += val; m_mode = MCollect; m_err = 0; taken = 1; end
      end
      if (prev == MCollect && m_mode == MCollect && !taken) begin
        m_idle++;
        if (m_idle == TOUT) begin m_mode = MChange; m_idle = 0; end
      end else begin
        m_idle = 0;
      end
    end else if (m_mode == MVend) begin
      e_rej = cv;
      m_mode = (m_credit > 0) ? MChange : MIdle;
    end else begin
      e_rej = cv;
      for (int k = 0; k < 3; k++) begin
        if (e_chg == 0 && m_credit >= coins[k]) begin
          e_chg = 1; e_ccoin = codes[k]; m_credit -= coins[k];
        end
      end
      if (m_credit == 0) m_mode = MIdle;
    end
  endtask

  task automatic compare_all(input string ctx);
    logic [31:0] so;
    so = '0;
    for (int i = 0; i < NP; i++) so[i] = (m_stock[i] == 0);
    chk({ctx, ":credit"}, 32'(credit), m_credit);
    chk({ctx, ":vend_valid"}, 32'(vend_valid), e_vend);
    if (e_vend != 0) chk({ctx, ":vend_addr"}, 32'(vend_addr), e_vaddr);
    chk({ctx, ":change_valid"}, 32'(change_valid), e_chg);
    if (e_chg != 0) chk({ctx, ":change_coin"}, 32'(change_coin), e_ccoin);
    chk({ctx, ":coin_reject"}, 32'(coin_reject), e_rej);
    chk({ctx, ":error"}, 32'(error), m_err);
    chk({ctx, ":sold_out"}, 32'(sold_out), so);
    chk({ctx, ":busy"}, 32'(busy), (m_mode == MVend || m_mode == MChange) ? 1 : 0);
  endtask

  task automatic cycle(input bit cv, input logic [3:0] ct, input bit sv, input int sa,
                       input bit cn, input string ctx);
    coin_valid = cv; coin_type = ct; select_valid = sv; select_addr = 3'(sa); cancel = cn;
    model_step(cv, ct, sv, sa, cn);
    @(posedge clock); #1;
    coin_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0;
    compare_all(ctx);
  endtask

  task automatic idle(input string ctx);
    cycle(1'b0, 4'b0, 1'b0, 0, 1'b0, ctx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    compare_all("reset");
    chk("reset:vend_addr", 32'(vend_addr), 0);
    chk("reset:change_coin", 32'(change_coin), 0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    @(posedge clock); #1;
    do_reset();

    // Buy slot 2 (1500) with a 2000 coin, expect one 500 back.
    cycle(1, 4'b0100, 0, 0, 0, "tp1_coin");
    chk("tp1_credit", 32'(credit), 2000);
    cycle(0, 4'b0, 1, 2, 0, "tp1_sel");
    chk("tp1_vend_addr", 32'(vend_addr), 2);
    idle("tp1_vend");
    idle("tp1_chg");
    chk("tp1_chg_coin", 32'(change_coin), 1);
    idle("tp1_done");

    // Insufficient credit, then cancel refund.
    cycle(1, 4'b0001, 0, 0, 0, "tp2_coin");
    cycle(0, 4'b0, 1, 3, 0, "tp2_sel");
    chk("tp2_error", 32'(error), 2);
    cycle(0, 4'b0, 0, 0, 1, "tp2_cancel");
    idle("tp2_chg");
    idle("tp2_done");

    // Drain slot 0.
    for (int n = 0; n < 5; n++) begin
      cycle(1, 4'b0001, 0, 0, 0, "tp3_coin");
      cycle(0, 4'b0, 1, 0, 0, "tp3_sel");
      if (n < 4) idle("tp3_vend");
    end
    chk("tp3_sold_out0", 32'(sold_out[0]), 1);
    chk("tp3_error", 32'(error), 3);
    cycle(0, 4'b0, 0, 0, 1, "tp3_cancel");
    idle("tp3_chg");

    // Inactivity refund of 5000.
    cycle(1, 4'b1000, 0, 0, 0, "tp4_coin");
    pulses = 0;
    for (int n = 0; n < TOUT + 4; n++) begin
      idle("tp4_wait");
      if (change_valid) pulses++;
    end
    chk("tp4_pulses", 32'(pulses), 3);
    chk("tp4_credit", 32'(credit), 0);

    // Priority: cancel wins over select and coin.
    cycle(1, 4'b0010, 0, 0, 0, "tp5_coin");
    cycle(1, 4'b0001, 1, 0, 1, "tp5_all");
    chk("tp5_reject", 32'(coin_reject), 1);
    idle("tp5_chg");
    chk("tp5_chg_coin", 32'(change_coin), 2);
    idle("tp5_done");
    cycle(1, 4'b0110, 0, 0, 0, "tp5_bad");
    chk("tp5_bad_err", 32'(error), 1);

    // Reset during change abandons the rest and restores stock.
    cycle(1, 4'b1000, 0, 0, 0, "tp6_coin");
    cycle(0, 4'b0, 0, 0, 1, "tp6_cancel");
    idle("tp6_chg1");
    chk("tp6_credit_mid", 32'(credit), 3000);
    do_reset();
    for (int n = 0; n < 4; n++) idle("tp6_after");
    chk("tp6_sold_out", 32'(sold_out), 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ct;
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        ct = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'(1 << $urandom_range(3));
        cycle($urandom_range(99) < 35, ct, $urandom_range(99) < 15, int'($urandom_range(NP - 1)),
              $urandom_range(99) < 4, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Parametrised next-generation vending controller that merges coin acceptance, product selection, stock tracking and change return into one FSM. It accepts one-hot coin pulses and product selects, and dispenses exactly one product per purchase. Change is returned greedily, one coin per cycle. An inactivity timeout triggers a full refund. It sits between the coin/keypad front end and the dispense/change actuators.

Parameters:
NUM_PRODUCTS, 8, number of product slots; ADDR_W = $clog2(NUM_PRODUCTS)
PRICE_STEP, 500, price of slot i is (i+1)*PRICE_STEP
TOTAL_W, 16, credit register width
MAX_CREDIT, 20000, credit ceiling; a coin that would exceed it is rejected
STOCK_W, 4, per-slot stock counter width
STOCK_INIT, 4, stock loaded into every slot on reset
TIMEOUT, 255, idle cycles in COLLECT before auto-refund

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
coin_valid  in  1  coin present this cycle
coin_type  in  4  one-hot: 0001=500, 0010=1000, 0100=2000, 1000=5000
select_valid  in  1  product request this cycle
select_addr  in  ADDR_W  requested slot
cancel  in  1  refund request
credit  out  TOTAL_W  current credit
vend_valid  out  1  one-cycle dispense pulse
vend_addr  out  ADDR_W  slot dispensed; valid with vend_valid
change_valid  out  1  one-cycle pulse, one coin returned
change_coin  out  3  one-hot: 001=500, 010=1000, 100=2000
coin_reject  out  1  one-cycle pulse; the coin was not counted
error  out  3  0 none, 1 invalid coin, 2 insufficient credit, 3 sold out, 4 overflow, 5 bad state
sold_out  out  NUM_PRODUCTS  bit i set when stock[i]==0
busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (async): state=IDLE, credit=0, all pulses 0, vend_addr=0, change_coin=0, error=0, every stock=STOCK_INIT, timer=0. Reset mid-CHANGE abandons the remaining change without any further pulses.
- All outputs are registered. sold_out and busy are decoded from registers.
- States: IDLE, COLLECT, VEND, CHANGE.
- Input priority in IDLE/COLLECT, same cycle: cancel > select_valid > coin_valid. Lower-priority inputs in that cycle are ignored; an ignored coin pulses coin_reject.
- Coin, accepted path: a valid one-hot coin with credit+value <= MAX_CREDIT adds value to credit at the next edge, sets state=COLLECT, clears error, and reloads the timer.
- Coin, invalid pattern (not one-hot, or 0000 with coin_valid high): coin_reject=1, error=1, credit unchanged.
- Coin, overflow: coin_reject=1, error=4.
- Coin during VEND/CHANGE: coin_reject=1, error unchanged.
- Select in IDLE/COLLECT:
  - stock[addr]==0: error=3, no state change.
  - credit < price: error=2, no state change.
  - Otherwise, at the next edge: credit -= price, stock[addr] -= 1, state=VEND, error=0.
- VEND lasts one cycle: vend_valid=1 and vend_addr=addr in that cycle. Next state is CHANGE if credit>0, else IDLE.
- Cancel in COLLECT goes to CHANGE, with vend_valid never asserted. Cancel in IDLE is a no-op.
- CHANGE: at each edge while credit>0, pulse change_valid with the largest coin <= credit and subtract its value. Credit is always a multiple of 500, so the greedy choice terminates. The edge on which credit reaches 0 sets state=IDLE. First coin appears one cycle after entry. Refunding N coins takes N cycles.
- Timer: counts cycles in COLLECT without an accepted coin or select. When it reaches TIMEOUT, state goes to CHANGE (full refund). An accepted input on the terminal cycle reloads the timer instead.
- select_addr >= NUM_PRODUCTS is treated as sold out (error=3).
- Unreachable state encoding: go to IDLE and set error=5, credit preserved.
- Widths: prices are computed at elaboration to TOTAL_W bits. Credit never wraps, guaranteed by the MAX_CREDIT check.

Decomposition:
- Package vend_pkg: coin one-hot encodings and values, change_coin encodings, error codes, state enum, price function price_of(i).
- Sub-module change_dispenser: greedy coin selection over credit (credit in, coin one-hot and value out). It is the only natural split; stock and timer stay inline.

Test Plan:
- Reset, then insert 2000, then select addr 2 (price 1500): credit=2000, then vend_valid with vend_addr=2, then one change pulse 001 (500), credit=0, IDLE; stock[2]=3.
- Insert 500 then select addr 3 (price 2000): error=2, no vend_valid, credit stays 500; then cancel: one 500 change pulse, credit=0.
- Buy slot 0 five times with exact 500 each: first four vend; fifth gives error=3 with credit still 500; sold_out[0]=1.
- Insert 5000, wait TIMEOUT idle cycles: auto refund of 2000, 2000, 1000 on three consecutive change pulses.
- Same-cycle cancel+select+coin in COLLECT with credit 1000: refund of one 1000 pulse, coin_reject=1, no vend; coin_type=0110: coin_reject=1, error=1.
- Assert reset during CHANGE after the first of three pulses: no further pulses, credit=0, stock back to STOCK_INIT.
